// File: rtl/sfu_seq.sv
// sfu_seq: sequencer for the accumulate/ReLU special-function stage.
//
// For each of num_out outputs, reads num_acc partial sums from psum memory,
// drives the SFU acc control aligned with returned data (1-cycle memory
// latency), optionally rectifies the sum, then writes the result back.
//
// Optional feature macro: SFU_SEQ_RELU_EN
//   defined   : RELU state present, relu_en_i honoured.
//   undefined : RELU state never entered, sfu_relu_o/sfu_in_zero_o tied 0.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start_i             job start (sampled in IDLE only)
//   relu_en_i           rectify results (latched at start)
//   num_acc_i           partial sums per output K (latched at start)
//   num_out_i           outputs per job N (latched at start)
//   rd_base_i/wr_base_i psum read / result write base (latched at start)
//   busy_o, done_o      job in progress / one-cycle end-of-job pulse
//   pmem_rd_o/_addr_o   psum read request
//   pmem_wr_o/_addr_o   result write request
//   sfu_acc_o           SFU accumulate (first cycle of a run loads)
//   sfu_relu_o          SFU rectify
//   sfu_in_zero_o       force SFU psum_in mux to 0
module sfu_seq #(
  parameter int addr_bw = 11,
  parameter int cnt_bw  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_i,
  input  logic               relu_en_i,
  input  logic [cnt_bw-1:0]  num_acc_i,
  input  logic [cnt_bw-1:0]  num_out_i,
  input  logic [addr_bw-1:0] rd_base_i,
  input  logic [addr_bw-1:0] wr_base_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               pmem_rd_o,
  output logic [addr_bw-1:0] pmem_rd_addr_o,
  output logic               pmem_wr_o,
  output logic [addr_bw-1:0] pmem_wr_addr_o,
  output logic               sfu_acc_o,
  output logic               sfu_relu_o,
  output logic               sfu_in_zero_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_RELU  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_FIN   = 3'd5;

  logic [2:0]         state_q,   state_d;
  logic [cnt_bw-1:0]  k_q,       k_d;
  logic [cnt_bw-1:0]  o_q,       o_d;
  logic [addr_bw-1:0] pass_q,    pass_d;    // running k*N
  logic [cnt_bw-1:0]  num_acc_q, num_acc_d;
  logic [cnt_bw-1:0]  num_out_q, num_out_d;
  logic [addr_bw-1:0] rd_base_q, rd_base_d;
  logic [addr_bw-1:0] wr_base_q, wr_base_d;
  logic               acc_q,     acc_d;
`ifdef SFU_SEQ_RELU_EN
  logic               relu_q,    relu_d;
`else
  logic               unused_relu_en;
  assign unused_relu_en = relu_en_i;
`endif

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    o_d       = o_q;
    pass_d    = pass_q;
    num_acc_d = num_acc_q;
    num_out_d = num_out_q;
    rd_base_d = rd_base_q;
    wr_base_d = wr_base_q;
`ifdef SFU_SEQ_RELU_EN
    relu_d    = relu_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          num_acc_d = num_acc_i;
          num_out_d = num_out_i;
          rd_base_d = rd_base_i;
          wr_base_d = wr_base_i;
`ifdef SFU_SEQ_RELU_EN
          relu_d    = relu_en_i;
`endif
          k_d       = '0;
          o_d       = '0;
          pass_d    = '0;
          state_d   = (num_acc_i == '0 || num_out_i == '0) ? S_FIN : S_READ;
        end
      end
      S_READ: begin
        k_d    = k_q + cnt_bw'(1);
        pass_d = pass_q + addr_bw'(num_out_q);
        if (k_q == num_acc_q - cnt_bw'(1)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
`ifdef SFU_SEQ_RELU_EN
        state_d = relu_q ? S_RELU : S_WRITE;
`else
        state_d = S_WRITE;
`endif
      end
      S_RELU:  state_d = S_WRITE;
      S_WRITE: begin
        o_d     = o_q + cnt_bw'(1);
        k_d     = '0;
        pass_d  = '0;
        // o_q <= N-1 here, so o_q+1 cannot overflow cnt_bw
        state_d = ((o_q + cnt_bw'(1)) == num_out_q) ? S_FIN : S_READ;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // acc follows the read by one cycle, aligned with returned psum data
  assign acc_d = (state_q == S_READ);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      o_q       <= '0;
      pass_q    <= '0;
      num_acc_q <= '0;
      num_out_q <= '0;
      rd_base_q <= '0;
      wr_base_q <= '0;
      acc_q     <= 1'b0;
`ifdef SFU_SEQ_RELU_EN
      relu_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      o_q       <= o_d;
      pass_q    <= pass_d;
      num_acc_q <= num_acc_d;
      num_out_q <= num_out_d;
      rd_base_q <= rd_base_d;
      wr_base_q <= wr_base_d;
      acc_q     <= acc_d;
`ifdef SFU_SEQ_RELU_EN
      relu_q    <= relu_d;
`endif
    end
  end

  assign busy_o    = (state_q == S_READ) || (state_q == S_DRAIN) ||
                     (state_q == S_RELU) || (state_q == S_WRITE);
  assign done_o    = (state_q == S_FIN);
  assign pmem_rd_o = (state_q == S_READ);
  assign pmem_wr_o = (state_q == S_WRITE);
  assign sfu_acc_o = acc_q;

  // Addresses are gated so idle outputs stay at zero
  assign pmem_rd_addr_o = pmem_rd_o ? (rd_base_q + pass_q + addr_bw'(o_q)) : '0;
  assign pmem_wr_addr_o = pmem_wr_o ? (wr_base_q + addr_bw'(o_q)) : '0;

`ifdef SFU_SEQ_RELU_EN
  assign sfu_relu_o    = (state_q == S_RELU);
  assign sfu_in_zero_o = (state_q == S_RELU);
`else
  assign sfu_relu_o    = 1'b0;
  assign sfu_in_zero_o = 1'b0;
`endif

endmodule

// File: tb/tb_sfu_seq.sv
// Bench for sfu_seq: cycle model from per-output timing rules, a small
// memory+SFU model for written data, and directed jobs with literal checks.
module tb_sfu_seq;
  localparam int AW = 11;
  localparam int CW = 8;
`ifdef SFU_SEQ_RELU_EN
  localparam int RB = 1;
`else
  localparam int RB = 0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          relu_en = 1'b0;
  logic [CW-1:0] num_acc = '0;
  logic [CW-1:0] num_out = '0;
  logic [AW-1:0] rd_base = '0;
  logic [AW-1:0] wr_base = '0;
  logic          busy, done, pmem_rd, pmem_wr, sfu_acc, sfu_relu, sfu_in_zero;
  logic [AW-1:0] pmem_rd_addr, pmem_wr_addr;

  sfu_seq #(.addr_bw(AW), .cnt_bw(CW)) dut (
    .clk(clk), .reset(reset), .start_i(start), .relu_en_i(relu_en),
    .num_acc_i(num_acc), .num_out_i(num_out), .rd_base_i(rd_base),
    .wr_base_i(wr_base), .busy_o(busy), .done_o(done), .pmem_rd_o(pmem_rd),
    .pmem_rd_addr_o(pmem_rd_addr), .pmem_wr_o(pmem_wr),
    .pmem_wr_addr_o(pmem_wr_addr), .sfu_acc_o(sfu_acc),
    .sfu_relu_o(sfu_relu), .sfu_in_zero_o(sfu_in_zero));

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int psum [0:2047];
  int rd_q[$];
  int wa_q[$];
  int wd_q[$];
  int done_cnt = 0;
  int relu_cnt = 0;

  task automatic check(input string nm, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic chk_vec(input logic [28:0] got, input logic [28:0] exp, input int t);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL cycle_model @%0t mt=%0d: got %h expected %h", $time, t, got, exp);
    end
  endtask

  task automatic chk_q(input string nm, input int got[$], input int exp[$]);
    check({nm, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check($sformatf("%s[%0d]", nm, i), got[i], exp[i]);
  endtask

  // ---------------- cycle model ----------------
  // mt = cycles since the accepting edge; each output takes K+2(+1 for ReLU)
  bit mactive = 0, chk_en = 0, mr = 0;
  int mt = 0, mdone = 0, mK = 0, mN = 0, mrb = 0, mwb = 0;

  always @(posedge clk) begin
    if (reset) begin
      mactive <= 0;
      chk_en  <= 1;
    end else if (mactive) begin
      if (mt == mdone) mactive <= 0;
      else mt <= mt + 1;
    end else if (start) begin
      mactive <= 1;
      mt      <= 1;
      mK      <= int'(num_acc);
      mN      <= int'(num_out);
      mrb     <= int'(rd_base);
      mwb     <= int'(wr_base);
      mr      <= (RB != 0) && relu_en;
      mdone   <= (num_acc == 0 || num_out == 0) ? 1 :
                 1 + int'(num_out) * (int'(num_acc) + 2 + (((RB != 0) && relu_en) ? 1 : 0));
    end
  end

  function automatic logic [28:0] model_vec();
    bit eb = 0, ed = 0, er = 0, ew = 0, ea = 0, el = 0;
    int era = 0, ewa = 0, per, p, o;
    if (mactive) begin
      if (mt == mdone) ed = 1;
      else begin
        eb  = 1;
        per = mK + 2 + (mr ? 1 : 0);
        p   = (mt - 1) % per;
        o   = (mt - 1) / per;
        er  = (p < mK);
        if (er) era = (mrb + p * mN + o) % (1 << AW);
        ea  = (p >= 1) && (p <= mK);
        el  = mr && (p == mK + 1);
        ew  = (p == per - 1);
        if (ew) ewa = (mwb + o) % (1 << AW);
      end
    end
    return {eb, ed, er, era[AW-1:0], ew, ewa[AW-1:0], ea, el, el};
  endfunction

  always @(negedge clk)
    if (chk_en)
      chk_vec({busy, done, pmem_rd, pmem_rd_addr, pmem_wr, pmem_wr_addr,
               sfu_acc, sfu_relu, sfu_in_zero}, model_vec(), mt);

  // ---------------- memory + SFU model, trace capture ----------------
  bit pend_v = 0, acc_prev = 0;
  logic [AW-1:0] pend_a = '0;
  int sfu_sum = 0;

  function automatic int sfu_next();
    int s, d;
    s = sfu_sum;
    d = pend_v ? psum[pend_a] : 0;
    if (sfu_acc) s = acc_prev ? s + d : d;
    if (sfu_relu && s < 0) s = 0;
    return s;
  endfunction

  always @(negedge clk) begin
    if (pmem_wr) begin
      wa_q.push_back(int'(pmem_wr_addr));
      wd_q.push_back(sfu_next());
    end
    if (pmem_rd) rd_q.push_back(int'(pmem_rd_addr));
    if (done) done_cnt <= done_cnt + 1;
    if (sfu_relu) relu_cnt <= relu_cnt + 1;
    sfu_sum  <= sfu_next();
    acc_prev <= sfu_acc;
    pend_v   <= pmem_rd;
    pend_a   <= pmem_rd_addr;
  end

  // ---------------- stimulus ----------------
  task automatic run_job(input int K, input int N, input int rb, input int wb,
                         input bit r, input bit poke, output int dcyc);
    rd_q.delete(); wa_q.delete(); wd_q.delete();
    done_cnt = 0; relu_cnt = 0;
    num_acc = CW'(K); num_out = CW'(N);
    rd_base = AW'(rb); wr_base = AW'(wb); relu_en = r;
    start = 1'b1;
    @(posedge clk); #3 start = 1'b0;
    dcyc = -1;
    for (int t = 1; t <= 600; t++) begin
      @(negedge clk);
      if (poke && t == 3) begin
        start = 1'b1; num_acc = 8'd7; num_out = 8'd9;
        rd_base = 11'd500; wr_base = 11'd600; relu_en = ~relu_en;
      end
      if (poke && t == 5) start = 1'b0;
      if (done) begin
        dcyc = t;
        break;
      end
    end
    if (dcyc < 0) begin
      vectors++; miscompares++;
      $display("FAIL done_timeout: got none expected pulse within 600 cycles");
    end
    @(posedge clk); #3;
  endtask

  int dc;

  initial begin
    for (int i = 0; i < 2048; i++) psum[i] = (i % 7) - 3;
    psum[0] = 5; psum[2] = -9; psum[4] = 1;
    psum[1] = 5; psum[3] = 9;  psum[5] = 1;
    psum[200] = 11; psum[201] = -4; psum[202] = 7;
    psum[2046] = 2; psum[2047] = 3;

    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
    @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_rd", int'(pmem_rd), 0);
    check("rst_acc", int'(sfu_acc), 0);
    @(posedge clk); #3;

    // K=3 N=2 with ReLU request; output 0 sums to -3, output 1 to 15
    run_job(3, 2, 0, 100, 1, 0, dc);
    check("A_done", dc, RB ? 13 : 11);
    chk_q("A_rd", rd_q, '{0, 2, 4, 1, 3, 5});
    chk_q("A_wa", wa_q, '{100, 101});
    chk_q("A_wd", wd_q, '{RB ? 0 : -3, 15});
    check("A_relu", relu_cnt, RB ? 2 : 0);

    // relu off, K=1 N=3, started the cycle after the previous done
    run_job(1, 3, 200, 300, 0, 0, dc);
    check("B_done", dc, 10);
    check("B_relu", relu_cnt, 0);
    chk_q("B_rd", rd_q, '{200, 201, 202});
    chk_q("B_wa", wa_q, '{300, 301, 302});
    chk_q("B_wd", wd_q, '{11, -4, 7});

    // degenerate jobs
    run_job(0, 5, 10, 20, 1, 0, dc);
    check("K0_done", dc, 1);
    check("K0_rd", rd_q.size(), 0);
    check("K0_wr", wa_q.size(), 0);
    run_job(4, 0, 10, 20, 1, 0, dc);
    check("N0_done", dc, 1);
    check("N0_rd", rd_q.size(), 0);
    check("N0_wr", wa_q.size(), 0);

    // start and config toggled while busy: trace must be unchanged
    run_job(3, 2, 0, 100, 1, 1, dc);
    check("P_done", dc, RB ? 13 : 11);
    check("P_donecnt", done_cnt, 1);
    chk_q("P_rd", rd_q, '{0, 2, 4, 1, 3, 5});
    chk_q("P_wa", wa_q, '{100, 101});

    // address wrap at 2^11
    run_job(3, 2, 2046, 2047, 0, 0, dc);
    chk_q("W_rd", rd_q, '{2046, 0, 2, 2047, 1, 3});
    chk_q("W_wa", wa_q, '{2047, 0});
    chk_q("W_wd", wd_q, '{-2, 17});

    // reset during the READ phase of output 1
    num_acc = 8'd3; num_out = 8'd2; rd_base = '0; wr_base = 11'd100; relu_en = 1'b1;
    start = 1'b1;
    @(posedge clk); #3 start = 1'b0;
    repeat (3 + 2 + RB + 2) @(negedge clk);
    check("R_inread", int'(pmem_rd), 1);
    @(posedge clk); #3 reset = 1'b1;
    @(posedge clk); #3 reset = 1'b0;
    done_cnt = 0;
    @(negedge clk);
    check("R_busy", int'(busy), 0);
    check("R_rd", int'(pmem_rd), 0);
    check("R_wr", int'(pmem_wr), 0);
    check("R_acc", int'(sfu_acc), 0);
    rd_q.delete();
    repeat (20) @(negedge clk);
    check("R_nodone", done_cnt, 0);
    check("R_noacc", rd_q.size(), 0);
    @(posedge clk); #3;
    run_job(3, 2, 0, 100, 1, 0, dc);
    check("R2_done", dc, RB ? 13 : 11);
    chk_q("R2_rd", rd_q, '{0, 2, 4, 1, 3, 5});
    chk_q("R2_wd", wd_q, '{RB ? 0 : -3, 15});

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
